// File: rtl/ssp_rx_ctrl.sv
// ssp_rx_ctrl
// ------------------------------------------------------------------------
// Receive-side sequencer for the SSP block. It samples the serial frame
// interface (sspclkin, sspfssin, ssprxd) in the pclk domain and assembles
// each DATA_W-bit frame MSB-first. It pushes the completed word into RxFIFO,
// refuses to write when the FIFO is full, flags receive overrun, and drives
// the receive interrupt from the FIFO empty flag.
//
// Build option:
//   SSP_RX_SYNC_EN : each serial input passes through a two-flop
//                    synchronizer before the edge-detect stage. This adds
//                    two pclk cycles of latency. When the macro is
//                    undefined, the inputs feed the edge-detect stage
//                    directly.
//
// Ports:
//   pclk        system clock, rising edge
//   clr_b       asynchronous active-low reset
//   sspclkin    serial bit clock (<= pclk/4), sampled as data
//   sspfssin    frame sync, high for one serial period before the MSB
//   ssprxd      serial receive data
//   fifo_full   RxFIFO full flag
//   fifo_empty  RxFIFO empty flag
//   ovr_clr     one-cycle pulse that clears rx_overrun
//   rx_push     one-cycle write strobe to RxFIFO
//   rx_data     assembled frame, valid while rx_push is high
//   rx_overrun  sticky: a frame was dropped because the FIFO was full
//   ssprxintr   receive interrupt, registered ~fifo_empty
//   busy        FSM is not in IDLE
//   state_dbg   current FSM state encoding (IDLE=0, SHIFT=1, PUSH=2)
//
// Handshake: rx_push is a write strobe with no ready. fifo_full acts as
// not-ready. rx_push is high only in the PUSH cycle, and only when
// fifo_full is low in that same cycle. A word offered while the FIFO is
// full is dropped and counted as an overrun. It is never retried.
// ------------------------------------------------------------------------
module ssp_rx_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              pclk,
    input  logic              clr_b,
    input  logic              sspclkin,
    input  logic              sspfssin,
    input  logic              ssprxd,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    input  logic              ovr_clr,
    output logic              rx_push,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_overrun,
    output logic              ssprxintr,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PUSH  = 2'd2
    } state_t;

    // ---------------------------------------------------------------
    // Input stage: {clk, fss, rxd} travel together so they stay aligned.
    // ---------------------------------------------------------------
    logic [2:0] in_raw;

`ifdef SSP_RX_SYNC_EN
    logic [2:0] sync1;
    logic [2:0] sync2;

    always_ff @(posedge pclk or negedge clr_b) begin
        if (!clr_b) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {sspclkin, sspfssin, ssprxd};
            sync2 <= sync1;
        end
    end

    assign in_raw = sync2;
`else
    assign in_raw = {sspclkin, sspfssin, ssprxd};
`endif

    logic [2:0] in_q;
    logic       clk_prev;

    always_ff @(posedge pclk or negedge clr_b) begin
        if (!clr_b) begin
            in_q     <= '0;
            clk_prev <= 1'b0;
        end else begin
            in_q     <= in_raw;
            clk_prev <= in_q[2];
        end
    end

    logic fe;
    logic fss_s;
    logic rxd_s;

    assign fe    = clk_prev & ~in_q[2];
    assign fss_s = in_q[1];
    assign rxd_s = in_q[0];

    // ---------------------------------------------------------------
    // Frame FSM
    // ---------------------------------------------------------------
    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              pending, pending_n;

    always_ff @(posedge pclk or negedge clr_b) begin
        if (!clr_b) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            shreg   <= shreg_n;
            pending <= pending_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shreg_n   = shreg;
        pending_n = pending;
        case (state)
            IDLE: begin
                if (fe && fss_s) begin
                    state_n   = SHIFT;
                    cnt_n     = '0;
                    pending_n = 1'b0;
                end
            end
            SHIFT: begin
                if (fe) begin
                    if (cnt == LAST_BIT) begin
                        shreg_n = {shreg[DATA_W-2:0], rxd_s};
                        state_n = PUSH;
                        // fss on the LSB edge announces an immediately
                        // following frame.
                        pending_n = fss_s;
                    end else if (fss_s) begin
                        // Sync seen mid-frame: drop the partial word and
                        // restart counting from the next edge.
                        cnt_n   = '0;
                        shreg_n = '0;
                    end else begin
                        shreg_n = {shreg[DATA_W-2:0], rxd_s};
                        cnt_n   = cnt + CNT_W'(1);
                    end
                end
            end
            PUSH: begin
                state_n   = pending ? SHIFT : IDLE;
                cnt_n     = '0;
                pending_n = 1'b0;
            end
            default: begin
                state_n   = IDLE;
                cnt_n     = '0;
                pending_n = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    logic in_push;
    logic drop;
    logic ovr_q;
    logic intr_q;

    assign in_push = (state == PUSH);
    assign drop    = in_push & fifo_full;

    // A new drop wins over a simultaneous clear.
    always_ff @(posedge pclk or negedge clr_b) begin
        if (!clr_b) begin
            ovr_q  <= 1'b0;
            intr_q <= 1'b0;
        end else begin
            if (drop) begin
                ovr_q <= 1'b1;
            end else if (ovr_clr) begin
                ovr_q <= 1'b0;
            end
            intr_q <= ~fifo_empty;
        end
    end

    assign rx_push    = in_push & ~fifo_full;
    assign rx_data    = shreg;
    // The drop term makes the flag visible in the cycle the push would
    // have occurred. The flop then holds it.
    assign rx_overrun = ovr_q | drop;
    assign ssprxintr  = intr_q;
    assign busy       = (state != IDLE);
    assign state_dbg  = state;

endmodule
